// File: rtl/qpu_exu_evt_sched.sv
`default_nettype none
// ============================================================================
// qpu_exu_evt_sched : timestamped event FIFO released by a local timeline.
// Optional same-cycle bypass: QPU_EVT_SCHED_BYPASS_EN.  Rev 1.0
// ============================================================================
module qpu_exu_evt_sched #(
    parameter int TIME_W  = 32,
    parameter int EDATA_W = 16,
    parameter int OPR_W   = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [TIME_W-1:0]          i_time,
    input  logic [EDATA_W-1:0]         i_edata,
    input  logic [OPR_W-1:0]           i_oprand,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [EDATA_W-1:0]         o_edata,
    output logic [OPR_W-1:0]           o_oprand,
    output logic [TIME_W-1:0]          o_time,
    output logic [TIME_W-1:0]          o_now,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_busy,
    output logic                       o_late,
    input  logic                       i_clr_late
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [TIME_W-1:0]  now_q;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW:0]        count_q, count_d;
    logic               late_q, late_d;

    logic [TIME_W-1:0]  time_mem_q  [DEPTH];
    logic [EDATA_W-1:0] edata_mem_q [DEPTH];
    logic [OPR_W-1:0]   opr_mem_q   [DEPTH];

    logic               not_empty, full, behind, due, pop, push, byp_hit, late_hit;
    logic [TIME_W-1:0]  head_time;
    logic [EDATA_W-1:0] head_edata;
    logic [OPR_W-1:0]   head_opr;

    assign not_empty  = (count_q != '0);
    assign full       = (count_q == CNT_FULL);
    assign head_time  = not_empty ? time_mem_q[rd_ptr_q]  : '0;
    assign head_edata = not_empty ? edata_mem_q[rd_ptr_q] : '0;
    assign head_opr   = not_empty ? opr_mem_q[rd_ptr_q]   : '0;

    // Sign of (now - time) gives a wrap-safe "now >= time" inside a half-range window.
    assign behind   = 1'((now_q - head_time) >> (TIME_W-1));
    assign due      = (state_q == ST_RUN) & not_empty & ~behind;
    assign pop      = due & o_ready;
    assign i_ready  = (~full | pop) & ~i_flush;
    assign late_hit = pop & (now_q != head_time);

`ifdef QPU_EVT_SCHED_BYPASS_EN
    assign byp_hit = (state_q == ST_RUN) & ~not_empty & i_valid & ~i_flush & (i_time == now_q);
`else
    assign byp_hit = 1'b0;
`endif

    // A bypassed event that is consumed immediately never enters the queue.
    assign push = i_valid & i_ready & ~(byp_hit & o_ready);

    assign o_valid  = due | byp_hit;
    assign o_edata  = byp_hit ? i_edata  : head_edata;
    assign o_oprand = byp_hit ? i_oprand : head_opr;
    assign o_time   = byp_hit ? i_time   : head_time;
    assign o_now    = now_q;
    assign o_count  = count_q;
    assign o_busy   = (state_q == ST_RUN) | not_empty;
    assign o_late   = late_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        late_d = late_hit | (late_q & ~i_clr_late);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            now_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            late_q   <= 1'b0;
        end else begin
            late_q <= late_d;
            if (i_flush) begin
                state_q  <= ST_IDLE;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                if (i_start) begin
                    state_q <= ST_RUN;
                    now_q   <= '0;
                end else if (state_q == ST_RUN) begin
                    now_q <= now_q + TIME_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            time_mem_q[wr_ptr_q]  <= i_time;
            edata_mem_q[wr_ptr_q] <= i_edata;
            opr_mem_q[wr_ptr_q]   <= i_oprand;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qpu_exu_evt_sched.sv
`default_nettype none
// ============================================================================
// tb_qpu_exu_evt_sched : directed + random scoreboard bench (8-bit timeline
// so that wrap-around is reachable).  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_qpu_exu_evt_sched;

    localparam int TW = 8;
    localparam int EW = 16;
    localparam int OW = 4;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_clr_late = 1'b0;
    logic          o_ready = 1'b0;
    logic [TW-1:0] i_time = '0;
    logic [EW-1:0] i_edata = '0;
    logic [OW-1:0] i_oprand = '0;
    logic          i_ready, o_valid, o_busy, o_late;
    logic [EW-1:0] o_edata;
    logic [OW-1:0] o_oprand;
    logic [TW-1:0] o_time, o_now;
    logic [CW-1:0] o_count;

    qpu_exu_evt_sched #(.TIME_W(TW), .EDATA_W(EW), .OPR_W(OW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_flush(i_flush),
        .i_valid(i_valid), .i_ready(i_ready), .i_time(i_time), .i_edata(i_edata),
        .i_oprand(i_oprand), .o_valid(o_valid), .o_ready(o_ready), .o_edata(o_edata),
        .o_oprand(o_oprand), .o_time(o_time), .o_now(o_now), .o_count(o_count),
        .o_busy(o_busy), .o_late(o_late), .i_clr_late(i_clr_late)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] t;
        logic [EW-1:0] e;
        logic [OW-1:0] o;
        int            vis;
    } ev_t;

    ev_t           sb[$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    bit            m_run = 0;
    logic [TW-1:0] m_now = '0;
    bit            m_late = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Event is due when the forward distance from its time to now is under half the range.
    function automatic bit is_due(input logic [TW-1:0] now, input logic [TW-1:0] t);
        int d;
        d = (int'(now) - int'(t) + (1 << TW)) % (1 << TW);
        return d < (1 << (TW-1));
    endfunction

    function automatic int vis_count(input int k);
        int n = 0;
        foreach (sb[i]) if (sb[i].vis <= k) n++;
        return n;
    endfunction

    function automatic bit byp_active();
`ifdef QPU_EVT_SCHED_BYPASS_EN
        return m_run && vis_count(cyc) == 0 && i_valid && !i_flush && i_time == m_now;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit head_due();
        return m_run && vis_count(cyc) > 0 && is_due(m_now, sb[0].t);
    endfunction

    task automatic step(input bit st, input bit fl, input bit v, input logic [TW-1:0] t,
                        input logic [EW-1:0] e, input logic [OW-1:0] o,
                        input bit rdy, input bit clr);
        bit qpop, acc;
        @(posedge clk);
        #1;
        i_start = st; i_flush = fl; i_valid = v; i_time = t;
        i_edata = e; i_oprand = o; o_ready = rdy; i_clr_late = clr;
        #1;
        qpop = head_due() && rdy;
        acc  = v && (vis_count(cyc) < DEPTH || qpop) && !fl;
        if (acc && !(byp_active() && rdy))
            sb.push_back('{t: t, e: e, o: o, vis: cyc + 1});
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, rdy, 0);
    endtask

    always @(negedge clk) begin
        int            n;
        bit            byp, ev, qpop, lset;
        logic [EW-1:0] ee;
        logic [OW-1:0] eo;
        logic [TW-1:0] et;
        if (!rst_n) begin
            sb.delete();
            m_run = 0; m_now = '0; m_late = 0;
        end else begin
            n   = vis_count(cyc);
            byp = byp_active();
            ev  = head_due() || byp;
            if (byp) begin
                ee = i_edata; eo = i_oprand; et = i_time;
            end else if (n > 0) begin
                ee = sb[0].e; eo = sb[0].o; et = sb[0].t;
            end else begin
                ee = '0; eo = '0; et = '0;
            end
            qpop = head_due() && o_ready;
            chk("now",   64'(o_now),   64'(m_now));
            chk("valid", 64'(o_valid), 64'(ev));
            chk("count", 64'(o_count), 64'(n));
            chk("late",  64'(o_late),  64'(m_late));
            chk("busy",  64'(o_busy),  64'(m_run || n > 0));
            chk("ready", 64'(i_ready), 64'((n < DEPTH || qpop) && !i_flush));
            chk("edata", 64'(o_edata), 64'(ee));
            chk("oprand",64'(o_oprand),64'(eo));
            chk("time",  64'(o_time),  64'(et));
            lset = qpop && (m_now != sb[0].t);
            m_late = lset || (m_late && !i_clr_late);
            if (qpop) void'(sb.pop_front());
            if (i_flush) begin
                sb.delete();
                m_run = 0;
            end else if (i_start) begin
                m_run = 1; m_now = '0;
            end else if (m_run) begin
                m_now = m_now + TW'(1);
            end
        end
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [TW-1:0] tt;
        // reset held for two cycles
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2, 0);

        // ordered issue: A at T=5, B at T=9
        step(1, 0, 0, '0, '0, '0, 1, 0);
        idle(1, 1);
        step(0, 0, 1, 8'd5, 16'h0011, 4'h1, 1, 0);
        step(0, 0, 1, 8'd9, 16'h0022, 4'h2, 1, 0);
        idle(10, 1);

        // backpressure, full queue, late issue and clear
        step(0, 1, 0, '0, '0, '0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 8'd3, 16'h0100 + 16'(i), 4'(i), 0, 0);
        step(1, 0, 0, '0, '0, '0, 0, 0);
        idle(6, 0);
        idle(6, 1);
        step(0, 0, 0, '0, '0, '0, 1, 1);
        idle(2, 1);

        // timeline wrap: push T=1 at now=0xFE
        step(1, 0, 0, '0, '0, '0, 1, 0);
        idle(254, 1);
        step(0, 0, 1, 8'd1, 16'h0A0A, 4'h5, 1, 0);
        idle(6, 1);

        // flush with a concurrent push
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 8'd100, 16'h0B00 + 16'(i), 4'h3, 1, 0);
        step(0, 1, 1, 8'd100, 16'hDEAD, 4'hF, 1, 0);
        idle(3, 1);

        // bypass candidate: empty queue, push T=7 at now=7
        step(1, 0, 0, '0, '0, '0, 1, 0);
        idle(7, 1);
        step(0, 0, 1, 8'd7, 16'h0777, 4'h7, 1, 0);
        idle(3, 1);
        step(0, 0, 0, '0, '0, '0, 1, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            tt = TW'(int'(m_now) + int'($urandom_range(0, 14)) - 2);
            step(($urandom % 60) == 0, ($urandom % 70) == 0, ($urandom % 2) == 0, tt,
                 16'($urandom), 4'($urandom), ($urandom % 4) != 0, ($urandom % 10) == 0);
        end
        idle(20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
